// File: rtl/reg_write_loader_pkg.sv
// Shared types and sizes for the front-panel register write loader.
// Holds the FSM state enum and the word/byte geometry.
package reg_write_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W = 8;
  localparam int DATA_W = 32;
  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  localparam logic [IDX_W-1:0] LAST_LANE =
    IDX_W'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    READY,
    WRITE
  } state_e;

endpackage

// File: rtl/reg_write_loader_if.sv
// Register-file write bus: W_Addr, W_Data, Write_Reg.
// master drives the bus (loader), slave receives it (register file).
interface reg_write_loader_if
  import reg_write_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
);

  logic [ADDR_WIDTH-1:0] W_Addr;
  logic [DATA_W-1:0]     W_Data;
  logic                  Write_Reg;

  modport master (
    output W_Addr,
    output W_Data,
    output Write_Reg
  );

  modport slave (
    input W_Addr,
    input W_Data,
    input Write_Reg
  );

endinterface

// File: rtl/reg_write_loader_btn_edge.sv
// btn_edge: raw async button -> one-cycle pulse on press.
// Ports: clk, rst_n, raw in, pulse out. REG_WRITE_LOADER_DEBOUNCE_EN adds debounce.
module btn_edge #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);

  if (DEBOUNCE_CYCLES < 1) begin : g_cfg_err
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

`ifdef REG_WRITE_LOADER_DEBOUNCE_EN

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          fired;

  // fired blocks further pulses until the level drops,
  // so a long press gives one pulse and release gives none.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      fired <= 1'b0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (!s2) begin
        cnt   <= '0;
        fired <= 1'b0;
      end else if (!fired) begin
        if (cnt == LIMIT) begin
          pulse <= 1'b1;
          fired <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

`else

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= s2;
      pulse <= s2 & ~prev;
    end
  end

`endif

endmodule

// File: rtl/reg_write_loader.sv
// Builds a 32-bit word byte-by-byte from SW, writes it on commit.
// Ports: Clk, Rst_n, SW, Addr_SW, Btn_Load, Btn_Commit, wr bus, Byte_Idx, Full.
// Optional debounce: define REG_WRITE_LOADER_DEBOUNCE_EN.
module reg_write_loader
  import reg_write_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [BYTE_W-1:0]     SW,
  input  logic [ADDR_WIDTH-1:0] Addr_SW,
  input  logic                  Btn_Load,
  input  logic                  Btn_Commit,
  reg_write_loader_if.master    wr,
  output logic [IDX_W-1:0]      Byte_Idx,
  output logic                  Full
);

  logic load_p;
  logic commit_p;

  btn_edge #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_load (
    .clk  (Clk),
    .rst_n(Rst_n),
    .raw  (Btn_Load),
    .pulse(load_p)
  );

  btn_edge #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_commit (
    .clk  (Clk),
    .rst_n(Rst_n),
    .raw  (Btn_Commit),
    .pulse(commit_p)
  );

  state_e state_q;
  state_e state_d;
  logic   do_load;
  logic   do_commit;

  logic [DATA_W-1:0]     data_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  full_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Commit has priority over a same-cycle load.
  always_comb begin
    state_d   = state_q;
    do_load   = 1'b0;
    do_commit = 1'b0;
    unique case (state_q)
      IDLE, FILL: begin
        if (commit_p) begin
          do_commit = 1'b1;
          state_d   = WRITE;
        end else if (load_p) begin
          do_load = 1'b1;
          state_d = (idx_q == LAST_LANE) ? READY : FILL;
        end
      end
      READY: begin
        if (commit_p) begin
          do_commit = 1'b1;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // W_Data is never cleared by commit; next word reuses it.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data_q <= '0;
      addr_q <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
    end else begin
      if (do_load) begin
        data_q[BYTE_W*idx_q +: BYTE_W] <= SW;
        idx_q <= idx_q + 1'b1;
        if (idx_q == LAST_LANE) begin
          full_q <= 1'b1;
        end
      end
      if (do_commit) begin
        addr_q <= Addr_SW;
      end
      if (state_q == WRITE) begin
        idx_q  <= '0;
        full_q <= 1'b0;
      end
    end
  end

  assign wr.W_Addr    = addr_q;
  assign wr.W_Data    = data_q;
  assign wr.Write_Reg = (state_q == WRITE);
  assign Byte_Idx     = idx_q;
  assign Full         = full_q;

endmodule

// File: tb/tb_reg_write_loader.sv
// Directed bench for reg_write_loader (DEBOUNCE_CYCLES = 4).
// Works with or without REG_WRITE_LOADER_DEBOUNCE_EN.
module tb_reg_write_loader;

  localparam int AW = 5;

`ifdef REG_WRITE_LOADER_DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 4;
`endif

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic [7:0]    SW = '0;
  logic [AW-1:0] Addr_SW = '0;
  logic          Btn_Load = 1'b0;
  logic          Btn_Commit = 1'b0;
  logic [1:0]    Byte_Idx;
  logic          Full;

  int n_cmp = 0;
  int n_bad = 0;

  reg_write_loader_if #(.ADDR_WIDTH(AW)) wr_if ();

  reg_write_loader #(
    .DEBOUNCE_CYCLES(4),
    .ADDR_WIDTH(AW)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .SW        (SW),
    .Addr_SW   (Addr_SW),
    .Btn_Load  (Btn_Load),
    .Btn_Commit(Btn_Commit),
    .wr        (wr_if.master),
    .Byte_Idx  (Byte_Idx),
    .Full      (Full)
  );

  always #5 Clk = ~Clk;

  // Press buttons for 10 cycles, observe 24 cycles of Write_Reg.
  task automatic press(
    input  bit          ld,
    input  bit          cm,
    output int          first,
    output int          n,
    output logic [4:0]  a,
    output logic [31:0] d
  );
    first = 0;
    n = 0;
    a = '0;
    d = '0;
    @(negedge Clk);
    Btn_Load = ld;
    Btn_Commit = cm;
    for (int k = 1; k <= 24; k++) begin
      @(negedge Clk);
      if (k == 10) begin
        Btn_Load = 1'b0;
        Btn_Commit = 1'b0;
      end
      if (wr_if.Write_Reg) begin
        if (n == 0) begin
          first = k;
          a = wr_if.W_Addr;
          d = wr_if.W_Data;
        end
        n++;
      end
    end
  endtask

  task automatic test_reset;
    Rst_n = 1'b0;
    repeat (3) @(negedge Clk);
    n_cmp++;
    if (wr_if.W_Data !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_wdata got %h want 0", wr_if.W_Data);
    end
    n_cmp++;
    if (wr_if.W_Addr !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_waddr got %0d want 0", wr_if.W_Addr);
    end
    n_cmp++;
    if (wr_if.Write_Reg !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_wreg got %b want 0", wr_if.Write_Reg);
    end
    n_cmp++;
    if (Byte_Idx !== 2'd0 || Full !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idx_full got %0d/%b want 0/0", Byte_Idx, Full);
    end
    Rst_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_fill;
    logic [7:0] bytes [4];
    int f, n, wr_total;
    logic [4:0] a;
    logic [31:0] d;
    bytes[0] = 8'h78;
    bytes[1] = 8'h56;
    bytes[2] = 8'h34;
    bytes[3] = 8'h12;
    wr_total = 0;
    for (int i = 0; i < 4; i++) begin
      SW = bytes[i];
      press(1'b1, 1'b0, f, n, a, d);
      wr_total += n;
      n_cmp++;
      if (Byte_Idx !== 2'((i + 1) % 4)) begin
        n_bad++;
        $display("FAIL fill_idx%0d got %0d want %0d", i, Byte_Idx, (i + 1) % 4);
      end
    end
    n_cmp++;
    if (wr_if.W_Data !== 32'h12345678) begin
      n_bad++;
      $display("FAIL fill_wdata got %h want 12345678", wr_if.W_Data);
    end
    n_cmp++;
    if (Full !== 1'b1) begin
      n_bad++;
      $display("FAIL fill_full got %b want 1", Full);
    end
    n_cmp++;
    if (wr_total != 0) begin
      n_bad++;
      $display("FAIL fill_no_write got %0d writes want 0", wr_total);
    end
  endtask

  task automatic test_ready_load;
    int f, n;
    logic [4:0] a;
    logic [31:0] d;
    SW = 8'hAA;
    press(1'b1, 1'b0, f, n, a, d);
    n_cmp++;
    if (wr_if.W_Data !== 32'h12345678 || Byte_Idx !== 2'd0) begin
      n_bad++;
      $display("FAIL ready_load got %h/%0d want 12345678/0", wr_if.W_Data, Byte_Idx);
    end
    n_cmp++;
    if (Full !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_full got %b want 1", Full);
    end
  endtask

  task automatic test_commit;
    int f, n;
    logic [4:0] a;
    logic [31:0] d;
    Addr_SW = 5'd7;
    press(1'b0, 1'b1, f, n, a, d);
    n_cmp++;
    if (n != 1 || f != LAT) begin
      n_bad++;
      $display("FAIL commit_pulse got n=%0d at %0d want n=1 at %0d", n, f, LAT);
    end
    n_cmp++;
    if (a !== 5'd7 || d !== 32'h12345678) begin
      n_bad++;
      $display("FAIL commit_bus got %0d/%h want 7/12345678", a, d);
    end
    n_cmp++;
    if (Full !== 1'b0 || Byte_Idx !== 2'd0) begin
      n_bad++;
      $display("FAIL commit_after got %b/%0d want 0/0", Full, Byte_Idx);
    end
    n_cmp++;
    if (wr_if.W_Data !== 32'h12345678) begin
      n_bad++;
      $display("FAIL commit_retain got %h want 12345678", wr_if.W_Data);
    end
  endtask

  task automatic test_partial;
    int f, n;
    logic [4:0] a;
    logic [31:0] d;
    SW = 8'hEF;
    press(1'b1, 1'b0, f, n, a, d);
    n_cmp++;
    if (wr_if.W_Data !== 32'h123456EF || Byte_Idx !== 2'd1 || Full !== 1'b0) begin
      n_bad++;
      $display("FAIL partial_load got %h/%0d/%b want 123456ef/1/0", wr_if.W_Data, Byte_Idx, Full);
    end
    Addr_SW = 5'd3;
    press(1'b0, 1'b1, f, n, a, d);
    n_cmp++;
    if (n != 1 || a !== 5'd3 || d !== 32'h123456EF) begin
      n_bad++;
      $display("FAIL partial_commit got n=%0d %0d/%h want n=1 3/123456ef", n, a, d);
    end
    n_cmp++;
    if (Byte_Idx !== 2'd0) begin
      n_bad++;
      $display("FAIL partial_idx got %0d want 0", Byte_Idx);
    end
  endtask

  task automatic test_back_to_back;
    int f, n;
    logic [4:0] a;
    logic [31:0] d;
    SW = 8'h99;
    Addr_SW = 5'd9;
    press(1'b1, 1'b1, f, n, a, d);
    n_cmp++;
    if (n != 1 || a !== 5'd9 || d !== 32'h123456EF) begin
      n_bad++;
      $display("FAIL both_write got n=%0d %0d/%h want n=1 9/123456ef", n, a, d);
    end
    n_cmp++;
    if (Byte_Idx !== 2'd0 || wr_if.W_Data !== 32'h123456EF) begin
      n_bad++;
      $display("FAIL both_noload got %0d/%h want 0/123456ef", Byte_Idx, wr_if.W_Data);
    end
  endtask

  task automatic test_glitch;
    logic [31:0] exp_d;
    logic [1:0]  exp_i;
`ifdef REG_WRITE_LOADER_DEBOUNCE_EN
    exp_d = 32'h1234565A;
    exp_i = 2'd1;
`else
    exp_d = 32'h12345A5A;
    exp_i = 2'd2;
`endif
    SW = 8'h5A;
    @(negedge Clk);
    Btn_Load = 1'b1;
    repeat (2) @(negedge Clk);
    Btn_Load = 1'b0;
    repeat (3) @(negedge Clk);
    Btn_Load = 1'b1;
    repeat (10) @(negedge Clk);
    Btn_Load = 1'b0;
    repeat (12) @(negedge Clk);
    n_cmp++;
    if (wr_if.W_Data !== exp_d || Byte_Idx !== exp_i) begin
      n_bad++;
      $display("FAIL glitch got %h/%0d want %h/%0d", wr_if.W_Data, Byte_Idx, exp_d, exp_i);
    end
  endtask

  task automatic test_reset_in_write;
    bit seen;
    seen = 1'b0;
    Addr_SW = 5'd1;
    @(negedge Clk);
    Btn_Commit = 1'b1;
    for (int k = 1; k <= 24 && !seen; k++) begin
      @(negedge Clk);
      if (wr_if.Write_Reg) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL rstwr_timeout got no Write_Reg want pulse");
    end else begin
      Rst_n = 1'b0;
      #1;
      n_cmp++;
      if (wr_if.Write_Reg !== 1'b0) begin
        n_bad++;
        $display("FAIL rstwr_wreg got %b want 0", wr_if.Write_Reg);
      end
      n_cmp++;
      if (wr_if.W_Data !== 32'h0 || wr_if.W_Addr !== 5'd0 ||
          Byte_Idx !== 2'd0 || Full !== 1'b0) begin
        n_bad++;
        $display("FAIL rstwr_outs got %h/%0d/%0d/%b want 0/0/0/0",
                 wr_if.W_Data, wr_if.W_Addr, Byte_Idx, Full);
      end
    end
    Btn_Commit = 1'b0;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_ready_load();
    test_commit();
    test_partial();
    test_back_to_back();
    test_glitch();
    test_reset_in_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_write_loader.md
# reg_write_loader

Front-panel input path for the register-file experiment: assembles a 32-bit write word from an 8-bit switch bank one byte at a time, then issues a single-cycle register-file write on a commit button. It is the write-side counterpart to the byte-wise LED readback path: the operator enters data byte-by-byte and reads it back byte-by-byte. It sits between the board switches/buttons and the register file's W_Addr / W_Data / Write_Reg inputs.

## Interface
- DEBOUNCE_CYCLES, 500000: cycles a button must be stable before it is accepted (10 ms at 50 MHz); used only with debounce compiled in.
- ADDR_WIDTH, 5: register address width.
- Clk  input  1  system clock, all state on rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- SW  input  8  data switches, byte to load.
- Addr_SW  input  ADDR_WIDTH  target register address switches.
- Btn_Load  input  1  raw button, asynchronous to Clk; loads SW into the current byte.
- Btn_Commit  input  1  raw button, asynchronous to Clk; writes the assembled word.
- W_Addr  output  ADDR_WIDTH  register-file write address.
- W_Data  output  32  assembled write word.
- Write_Reg  output  1  register-file write enable, one-cycle pulse.
- Byte_Idx  output  2  next byte lane to be loaded (0 = bits 7:0 … 3 = bits 31:24); drives the byte-lane indicator.
- Full  output  1  all four bytes loaded since the last commit.

## Operation
- Each button passes through btn_edge and becomes a one-cycle pulse: load_p or commit_p.
- States: IDLE, FILL, READY, WRITE.
- IDLE/FILL, load_p: W_Data[8*Byte_Idx +: 8] <= SW and Byte_Idx <= Byte_Idx+1.
  - If the loaded lane is 3: Byte_Idx wraps to 0, Full <= 1, go to READY.
  - Otherwise go to FILL.
- READY, load_p: ignored. No lane is overwritten and Byte_Idx is unchanged.
- IDLE/FILL/READY, commit_p: latch W_Addr <= Addr_SW and go to WRITE.
  - A partial commit from IDLE or FILL is legal; unloaded lanes keep their previous W_Data contents.
- WRITE: Write_Reg = 1 for exactly this cycle, then go to IDLE with Byte_Idx <= 0 and Full <= 0. Pulses arriving during WRITE are dropped.
- W_Data is retained after commit, not cleared. The next word starts from the previous contents.
- load_p and commit_p in the same cycle: commit wins and the load is dropped (W_Data unchanged).
- Reset values: W_Data = 0, W_Addr = 0, Write_Reg = 0, Byte_Idx = 0, Full = 0, state IDLE, synchronizer/debounce state cleared.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous). A Write_Reg pulse in progress is cut off.

## Timing
- btn_edge: 2-flop synchronizer, then a rising-edge detector. Pulse latency is 3 cycles from the raw edge, without debounce.
- With debounce: the pulse is emitted after the synchronized level has been stable high for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count. One pulse per press, and the release is never a pulse.
- Load: W_Data, Byte_Idx and Full update on the clock edge where load_p is high.
- Commit: Write_Reg is high in the cycle after commit_p. W_Addr and W_Data are stable through that cycle and unchanged until the next load or commit.
- Minimum spacing between accepted commits is 2 cycles. This is inherent, since WRITE lasts one cycle.

## Configuration
- REG_WRITE_LOADER_DEBOUNCE_EN defined: btn_edge includes the stability counter; DEBOUNCE_CYCLES applies.
- Not defined: synchronizer plus edge detect only. DEBOUNCE_CYCLES is ignored; simulation-friendly.

## Structure
- Shared package holds:
  - the state enum (IDLE, FILL, READY, WRITE);
  - BYTES_PER_WORD = 4, BYTE_W = 8, DATA_W = 32.
- One sub-module, btn_edge (raw in, pulse out, DEBOUNCE_CYCLES parameter), instantiated twice. The FSM and data path stay in the top module.

## Test plan
Bench uses DEBOUNCE_CYCLES = 4.
- Reset, then load SW = 8'h78, 8'h56, 8'h34, 8'h12 in order -> W_Data = 32'h12345678, Byte_Idx = 0, Full = 1, Write_Reg stays 0.
- From READY, Addr_SW = 5'd7 and press commit -> exactly one Write_Reg cycle, 1 cycle after commit_p, with W_Addr = 7 and W_Data = 32'h12345678; afterwards Full = 0, Byte_Idx = 0.
- Load 8'hAA in READY -> W_Data unchanged, Byte_Idx stays 0.
- Partial: after a 32'h12345678 commit, load 8'hEF then commit with Addr_SW = 3 -> W_Data = 32'h123456EF written to register 3.
- load_p and commit_p forced in the same cycle -> write issued, byte not loaded, Byte_Idx = 0.
- Two further scenarios:
  - With debounce compiled in, glitch Btn_Load high 2 cycles, low, then high 10 cycles -> exactly one load.
  - Assert Rst_n low while in WRITE -> Write_Reg drops immediately and all outputs are 0.
